// File: rtl/aes_stream_driver.sv
// Byte-serial sequencer for the S-box stream cipher: issues key/new_msg/in_valid
// per byte, captures out_flag results into a small valid/ready result FIFO.
module aes_stream_driver #(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 15,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_start,
  input  logic [7:0] msg_key,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       new_msg,
  output logic [7:0] key,
  output logic       in_valid,
  output logic [7:0] in,
  input  logic       out_flag,
  input  logic [7:0] out,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [3:0] GAP_C = 4'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_FETCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_GAP   = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  in_q, in_d;
  logic        last_q, last_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic        err_q, err_d;
  logic        new_msg_q, new_msg_d;
  logic        in_valid_q, in_valid_d;
  logic        s_ready_q, s_ready_d;
  logic        busy_q, busy_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]  mem_q [DEPTH];

  logic fifo_push, fifo_pop, fifo_wr, fifo_empty, fifo_full, full_d, hs;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign hs = s_valid && s_ready_q;

  // Next-state, datapath and FIFO pointer computation
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    in_d      = in_q;
    last_d    = last_q;
    tcnt_d    = tcnt_q;
    gcnt_d    = gcnt_q;
    err_d     = err_q;
    fifo_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (msg_start) begin
          key_d   = msg_key;
          err_d   = 1'b0;
          state_d = S_KEY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KEY: state_d = S_FETCH;
      S_FETCH: begin
        if (hs) begin
          in_d    = s_data;
          last_d  = s_last;
          state_d = S_ISSUE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        tcnt_d  = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result on the final allowed cycle still wins over the timeout
        if (out_flag) begin
          fifo_push = 1'b1;
          gcnt_d    = 4'd0;
          if (GAP_C != 4'd0) begin
            state_d = S_GAP;
          end else begin
            state_d = last_q ? S_IDLE : S_FETCH;
          end
        end else if ((tcnt_q + 8'd1) == TIMEOUT_C) begin
          err_d   = 1'b1;
          state_d = last_q ? S_IDLE : S_DRAIN;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gcnt_q == (GAP_C - 4'd1)) begin
          state_d = last_q ? S_IDLE : S_FETCH;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (hs && s_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    fifo_pop = m_ready && !fifo_empty;
    fifo_wr  = fifo_push && (!fifo_full || fifo_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, fifo_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, fifo_pop};
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    s_ready_d  = ((state_d == S_FETCH) && !full_d) || (state_d == S_DRAIN);
    new_msg_d  = (state_d == S_KEY);
    in_valid_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
  end

  // State, output and FIFO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= 8'h00;
      in_q       <= 8'h00;
      last_q     <= 1'b0;
      tcnt_q     <= 8'd0;
      gcnt_q     <= 4'd0;
      err_q      <= 1'b0;
      new_msg_q  <= 1'b0;
      in_valid_q <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 9'h000;
      end
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      in_q       <= in_d;
      last_q     <= last_d;
      tcnt_q     <= tcnt_d;
      gcnt_q     <= gcnt_d;
      err_q      <= err_d;
      new_msg_q  <= new_msg_d;
      in_valid_q <= in_valid_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (fifo_wr) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {out, last_q};
      end
    end
  end

  assign s_ready  = s_ready_q;
  assign new_msg  = new_msg_q;
  assign key      = key_q;
  assign in_valid = in_valid_q;
  assign in       = in_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign m_valid  = !fifo_empty;
  assign m_data   = m_valid ? mem_q[rd_ptr_q[AW-1:0]][8:1] : 8'h00;
  assign m_last   = m_valid ? mem_q[rd_ptr_q[AW-1:0]][0] : 1'b0;

endmodule

// File: tb/tb_aes_stream_driver.sv
// Directed + randomized bench for aes_stream_driver with an XOR cipher model
// and a queue-based scoreboard of expected {last, byte} results.
module tb_aes_stream_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       msg_start = 1'b0;
  logic [7:0] msg_key = 8'h00;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready, new_msg, in_valid, m_valid, m_last, busy, err;
  logic [7:0] key, in, m_data;
  logic       out_flag, m_ready;
  logic [7:0] out;

  always #5 clk = ~clk;

  aes_stream_driver #(.GAP_CYCLES(1), .TIMEOUT(15), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .msg_start(msg_start), .msg_key(msg_key),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .new_msg(new_msg), .key(key), .in_valid(in_valid), .in(in),
    .out_flag(out_flag), .out(out), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .err(err)
  );

  // Cipher model: out = in ^ key, out_flag pulsed lat cycles after in_valid
  int lat = 1, drop_at = -1, iv_seen = 0, cd = 0;
  logic cflag = 1'b0, spur = 1'b0;
  logic [7:0] cout = 8'h00, spur_data = 8'h00;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      cd = 0;
      cflag = 1'b0;
    end else begin
      cflag = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) cflag = 1'b1;
      end
      if (in_valid) begin
        if (iv_seen != drop_at) begin
          cd = lat;
          cout = in ^ key;
        end
        iv_seen++;
      end
    end
  end
  assign out_flag = cflag | spur;
  assign out = cflag ? cout : spur_data;

  logic mr_en = 1'b0, mr_fix = 1'b1, mr_rnd = 1'b0;
  always @(posedge clk) begin
    #1;
    mr_rnd = 1'($urandom_range(0, 1));
  end
  assign m_ready = mr_en ? mr_rnd : mr_fix;

  // Monitor, sampled mid-cycle
  int cyc = 0, n_nm = 0, start_cyc = 0, nm_cyc = 0, err_rise = 0;
  int busy_fall = 0, lasths_cyc = 0, iv_orphan = 0;
  bit prev_hs = 0, err_prev = 0, busy_prev = 0;
  int iv_q[$];
  logic [8:0] got_q[$], exp_q[$];
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (new_msg) begin n_nm++; nm_cyc = cyc; end
      if (msg_start && !busy) start_cyc = cyc;
      if (in_valid) begin
        iv_q.push_back(cyc);
        if (!prev_hs) iv_orphan++;
      end
      prev_hs = s_valid && s_ready;
      if (s_valid && s_ready && s_last) lasths_cyc = cyc;
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (err && !err_prev) err_rise = cyc;
      if (busy_prev && !busy) busy_fall = cyc;
      err_prev = err;
      busy_prev = busy;
    end else begin
      prev_hs = 0;
      err_prev = 0;
      busy_prev = 0;
    end
  end

  int total = 0, passed = 0;
  logic [7:0] dat [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [7:0] k);
    msg_key = k;
    msg_start = 1'b1;
    tick();
    msg_start = 1'b0;
  endtask

  task automatic wait_hs(output bit ok);
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = s_valid && s_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input int n, input int spur_idx, input int mid_idx,
                      input bit rnd_idle, output int sent);
    sent = 0;
    for (int i = 0; i < n; i++) begin
      bit ok;
      if (rnd_idle && ($urandom_range(0, 2) == 0)) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      s_valid = 1'b1;
      s_data = dat[i];
      s_last = (i == n - 1);
      wait_hs(ok);
      if (ok) sent++;
      s_valid = 1'b0;
      s_last = 1'b0;
      if (i == mid_idx) begin
        msg_key = ~msg_key;
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
      end
      if (i == spur_idx) begin
        // ISSUE -> WAIT -> GAP (spurious) -> FETCH -> FETCH (spurious)
        tick(); tick();
        spur_data = 8'($urandom); spur = 1'b1; tick();
        spur = 1'b0; tick();
        spur_data = 8'($urandom); spur = 1'b1; tick();
        spur = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input bit need_empty, input int bound);
    bit done = 0;
    for (int c = 0; c < bound && !done; c++) begin
      @(negedge clk);
      done = !busy && !(need_empty && m_valid);
    end
    @(posedge clk);
    #1;
    chk("idle_reached", {30'd0, busy, need_empty & m_valid}, 32'd0);
  endtask

  task automatic add_exp(input logic [7:0] k, input int n, input int drop_idx);
    for (int i = 0; i < n; i++)
      if (drop_idx < 0 || i < drop_idx) exp_q.push_back({(i == n - 1), dat[i] ^ k});
  endtask

  task automatic rand_dat(input int n);
    for (int i = 0; i < n; i++) dat[i] = 8'($urandom);
  endtask

  task automatic compare_results(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_entry"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int sent, nm0, t;
    bit ok;
    logic [7:0] k;
    logic [7:0] keys [3];

    // Reset values
    repeat (3) tick();
    chk("rst_new_msg", new_msg, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_in", in, 0);
    chk("rst_key", key, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single message, key 0x2B, bytes 0..4
    for (int i = 0; i < 5; i++) dat[i] = 8'(i);
    iv_q.delete();
    nm0 = n_nm;
    start_msg(8'h2B);
    add_exp(8'h2B, 5, -1);
    feed(5, -1, -1, 0, sent);
    wait_idle(1, 200);
    chk("s1_sent", sent, 5);
    chk("s1_new_msg_count", n_nm - nm0, 1);
    chk("s1_new_msg_time", nm_cyc - start_cyc, 1);
    chk("s1_iv_count", iv_q.size(), 5);
    chk("s1_first_iv_time", iv_q[0] - start_cyc, 3);
    for (int j = 1; j < 5; j++) chk("s1_iv_spacing", iv_q[j] - iv_q[j-1], 4);
    chk("s1_busy_fall", busy_fall - iv_q[4], 3);
    compare_results("s1");

    // Back-to-back keys, mid-message msg_start on the second one
    keys[0] = 8'h00; keys[1] = 8'hFF; keys[2] = 8'h5A;
    for (int m = 0; m < 3; m++) begin
      rand_dat(3);
      nm0 = n_nm;
      start_msg(keys[m]);
      chk("b2b_key_loaded", key, keys[m]);
      add_exp(keys[m], 3, -1);
      feed(3, -1, (m == 1) ? 0 : -1, 0, sent);
      wait_idle(0, 200);
      chk("b2b_sent", sent, 3);
      chk("b2b_new_msg_count", n_nm - nm0, 1);
      chk("b2b_key_held", key, keys[m]);
    end
    wait_idle(1, 50);
    compare_results("b2b");

    // Backpressure: FIFO fills at 4, stream stalls until m_ready rises
    rand_dat(6);
    k = 8'($urandom);
    iv_q.delete();
    mr_fix = 1'b0;
    start_msg(k);
    add_exp(k, 6, -1);
    fork
      feed(6, -1, -1, 0, sent);
      begin
        repeat (30) tick();
        chk("bp_iv_stalled", iv_q.size(), 4);
        chk("bp_s_ready_low", s_ready, 0);
        chk("bp_m_valid", m_valid, 1);
        mr_fix = 1'b1;
      end
    join
    wait_idle(1, 200);
    chk("bp_sent", sent, 6);
    chk("bp_iv_total", iv_q.size(), 6);
    compare_results("bp");

    // Timeout on byte 2 of 5, remaining bytes drained
    rand_dat(5);
    k = 8'($urandom);
    iv_q.delete();
    drop_at = iv_seen + 1;
    start_msg(k);
    add_exp(k, 5, 1);
    feed(5, -1, -1, 0, sent);
    wait_idle(1, 300);
    drop_at = -1;
    chk("to_sent", sent, 5);
    chk("to_err_set", err, 1);
    chk("to_iv_count", iv_q.size(), 2);
    chk("to_err_time", err_rise - iv_q[1], 16);
    chk("to_busy_fall", busy_fall - lasths_cyc, 1);
    compare_results("to");
    rand_dat(2);
    k = 8'($urandom);
    start_msg(k);
    chk("to_err_cleared", err, 0);
    add_exp(k, 2, -1);
    feed(2, -1, -1, 0, sent);
    wait_idle(1, 200);
    compare_results("to_next");

    // Spurious out_flag during GAP and FETCH
    rand_dat(4);
    k = 8'($urandom);
    start_msg(k);
    add_exp(k, 4, -1);
    feed(4, 1, -1, 0, sent);
    wait_idle(1, 200);
    chk("spur_sent", sent, 4);
    compare_results("spur");

    // Async reset while in WAIT
    rand_dat(2);
    k = 8'($urandom);
    mr_fix = 1'b0;
    lat = 5;
    start_msg(k);
    s_valid = 1'b1; s_data = dat[0]; s_last = 1'b0;
    wait_hs(ok);
    s_data = dat[1]; s_last = 1'b1;
    wait_hs(ok);
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    chk("ar_pre_m_valid", m_valid, 1);
    chk("ar_pre_busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_in_valid", in_valid, 0);
    chk("ar_new_msg", new_msg, 0);
    chk("ar_key", key, 0);
    chk("ar_in", in, 0);
    chk("ar_s_ready", s_ready, 0);
    chk("ar_m_valid", m_valid, 0);
    chk("ar_m_data", m_data, 0);
    chk("ar_err", err, 0);
    #2 rst = 1'b0;
    repeat (10) tick();
    chk("ar_idle_after", {in_valid, new_msg, busy, m_valid}, 0);
    got_q.delete();
    exp_q.delete();
    lat = 1;
    mr_fix = 1'b1;
    rand_dat(3);
    k = 8'($urandom);
    start_msg(k);
    add_exp(k, 3, -1);
    feed(3, -1, -1, 0, sent);
    wait_idle(1, 200);
    compare_results("ar_next");

    // Randomized messages: random keys, lengths, latency, idle and m_ready
    mr_en = 1'b1;
    for (int m = 0; m < 5; m++) begin
      int n;
      n = $urandom_range(1, 6);
      lat = $urandom_range(1, 4);
      rand_dat(n);
      k = 8'($urandom);
      start_msg(k);
      add_exp(k, n, -1);
      feed(n, -1, -1, 1, sent);
      chk("rnd_sent", sent, n);
      wait_idle(1, 400);
    end
    mr_en = 1'b0;
    compare_results("rnd");

    chk("iv_without_handshake", iv_orphan, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
